nn_batch_sequencer: RTL and testbench

Top-level controller that runs the neural-network inference core over a full test set and scores it. For each sample it:
- drives the sample index;
- pulses the core's start;
- waits for the core's done, with a watchdog;
- compares the returned class against the stored label;
- accumulates total and correct counts.

It sits between the system start strobe, the input/label memories and the inference core, and replaces bench-side scoring.

---
 rtl/nn_batch_sequencer.sv | 160 ++++++++++++++++
 tb/tb_nn_batch_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/nn_batch_sequencer.sv
// Batch controller: walks the inference core over every sample, scores each
// returned class against its stored label and guards each sample with a watchdog.
module nn_batch_sequencer #(
  parameter int unsigned NUM_SAMPLES    = 750,
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned LABEL_W        = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               timeout_err,
  output logic [ADDR_W-1:0]  sample_addr,
  input  logic [LABEL_W-1:0] label_in,
  output logic               core_start,
  input  logic               core_done,
  input  logic [LABEL_W-1:0] core_result,
  output logic               sample_done,
  output logic               sample_match,
  output logic [ADDR_W-1:0]  total_count,
  output logic [ADDR_W-1:0]  correct_count
);

  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 2);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_SAMPLES - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  total_q, total_d;
  logic [ADDR_W-1:0]  correct_q, correct_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               terr_q, terr_d;
  logic               core_start_q, core_start_d;
  logic               sample_done_q, sample_done_d;
  logic               sample_match_q, sample_match_d;

  // Next-state logic; every output flop is loaded with its value for the state being entered.
  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    addr_d         = addr_q;
    total_d        = total_q;
    correct_d      = correct_q;
    terr_d         = terr_q;
    busy_d         = 1'b0;
    done_d         = 1'b0;
    core_start_d   = 1'b0;
    sample_done_d  = 1'b0;
    sample_match_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d       = '0;
          total_d      = '0;
          correct_d    = '0;
          terr_d       = 1'b0;
          state_d      = ST_ISSUE;
          busy_d       = 1'b1;
          core_start_d = 1'b1;
        end
      end
      ST_ISSUE: begin
        timer_d = '0;
        state_d = ST_WAIT;
        busy_d  = 1'b1;
      end
      ST_WAIT: begin
        // Label data is already valid here; the address changed on entry to ISSUE.
        if (core_done) begin
          state_d        = ST_CHECK;
          busy_d         = 1'b1;
          sample_done_d  = 1'b1;
          sample_match_d = (core_result == label_in);
        end else begin
          timer_d = timer_q + TMR_W'(1);
          if (timer_q == TMR_LAST) begin
            terr_d  = 1'b1;
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            busy_d = 1'b1;
          end
        end
      end
      ST_CHECK: begin
        total_d = total_q + ADDR_W'(1);
        if (sample_match_q) begin
          correct_d = correct_q + ADDR_W'(1);
        end
        if (addr_q == ADDR_LAST) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          addr_d       = addr_q + ADDR_W'(1);
          state_d      = ST_ISSUE;
          busy_d       = 1'b1;
          core_start_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      timer_q        <= '0;
      addr_q         <= '0;
      total_q        <= '0;
      correct_q      <= '0;
      terr_q         <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      core_start_q   <= 1'b0;
      sample_done_q  <= 1'b0;
      sample_match_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      addr_q         <= addr_d;
      total_q        <= total_d;
      correct_q      <= correct_d;
      terr_q         <= terr_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      core_start_q   <= core_start_d;
      sample_done_q  <= sample_done_d;
      sample_match_q <= sample_match_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign timeout_err   = terr_q;
  assign sample_addr   = addr_q;
  assign core_start    = core_start_q;
  assign sample_done   = sample_done_q;
  assign sample_match  = sample_match_q;
  assign total_count   = total_q;
  assign correct_count = correct_q;

endmodule

// File: tb/tb_nn_batch_sequencer.sv
// Bench for nn_batch_sequencer: a scripted core responder and label memory,
// with a per-cycle timeline model built from per-sample latencies.
module tb_nn_batch_sequencer;

  localparam int unsigned NS = 4;
  localparam int unsigned AW = 3;
  localparam int unsigned LW = 8;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, timeout_err, core_start, sample_done, sample_match;
  logic [AW-1:0] sample_addr, total_count, correct_count;
  logic [LW-1:0] label_in;
  logic          core_done = 1'b0;
  logic [LW-1:0] core_result = '0;

  nn_batch_sequencer #(
    .NUM_SAMPLES(NS), .ADDR_W(AW), .LABEL_W(LW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .timeout_err(timeout_err), .sample_addr(sample_addr), .label_in(label_in),
    .core_start(core_start), .core_done(core_done), .core_result(core_result),
    .sample_done(sample_done), .sample_match(sample_match),
    .total_count(total_count), .correct_count(correct_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scenario tables: lat 0 means the core never answers that sample.
  logic [LW-1:0] labels [NS];
  logic [LW-1:0] res_tab [NS];
  int            lat_tab [NS];
  bit            stray_en = 1'b0;
  bit            mid_start = 1'b0;

  always @(posedge clk) label_in <= labels[sample_addr];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  // Core responder: answers lat cycles after each core_start; optional stray hold into CHECK.
  initial begin
    int a;
    int l;
    forever begin
      if (core_start === 1'b1) begin
        a = int'(sample_addr);
        l = lat_tab[a];
        if (l == 0) begin
          @(negedge clk);
        end else begin
          repeat (l) @(negedge clk);
          core_done   = 1'b1;
          core_result = res_tab[a];
          @(negedge clk);
          if (stray_en) @(negedge clk);
          core_done = 1'b0;
        end
      end else begin
        @(negedge clk);
      end
    end
  end

  // Reference timeline of one batch.
  int exp_cs [NS];
  int n_cs;
  int exp_chk [NS];
  bit exp_m [NS];
  int n_chk;
  int done_c;
  bit e_terr;
  int e_tot, e_cor;

  function automatic void build_model(input int s);
    int c;
    c = s + 1;
    n_cs = 0; n_chk = 0; e_terr = 1'b0; e_tot = 0; e_cor = 0; done_c = -1;
    for (int i = 0; i < int'(NS); i++) begin
      exp_cs[n_cs] = c;
      n_cs++;
      if (lat_tab[i] >= 1 && lat_tab[i] <= int'(TO) - 1) begin
        exp_chk[n_chk] = c + lat_tab[i] + 1;
        exp_m[n_chk]   = (res_tab[i] == labels[i]);
        e_tot++;
        if (exp_m[n_chk]) e_cor++;
        n_chk++;
        c = c + lat_tab[i] + 2;
      end else begin
        e_terr = 1'b1;
        done_c = c + int'(TO);
        break;
      end
    end
    if (done_c < 0) done_c = c;
  endfunction

  task automatic run_batch(input string name);
    int  s;
    bit  ecs, ech;
    int  ea, em;
    @(negedge clk);
    start = 1'b1;
    s = cyc;
    build_model(s);
    forever begin
      @(negedge clk);
      if (cyc == s + 1) start = 1'b0;
      if (mid_start && cyc == s + 5) start = 1'b1;
      if (mid_start && cyc == s + 6) start = 1'b0;
      ecs = 1'b0; ech = 1'b0; ea = 0; em = 0;
      for (int i = 0; i < n_cs; i++) if (exp_cs[i] == cyc) begin ecs = 1'b1; ea = i; end
      for (int i = 0; i < n_chk; i++) if (exp_chk[i] == cyc) begin ech = 1'b1; em = int'(exp_m[i]); end
      check_eq({name, ":core_start"}, 32'(core_start), 32'(ecs));
      if (ecs) check_eq({name, ":addr"}, 32'(sample_addr), 32'(ea));
      check_eq({name, ":sample_done"}, 32'(sample_done), 32'(ech));
      if (ech) check_eq({name, ":match"}, 32'(sample_match), 32'(em));
      check_eq({name, ":busy"}, 32'(busy), 32'(cyc >= s + 1 && cyc < done_c));
      check_eq({name, ":done"}, 32'(done), 32'(cyc == done_c));
      if (cyc == s + 1) begin
        check_eq({name, ":clr_terr"}, 32'(timeout_err), 32'(0));
        check_eq({name, ":clr_total"}, 32'(total_count), 32'(0));
        check_eq({name, ":clr_correct"}, 32'(correct_count), 32'(0));
      end
      if (cyc == done_c) begin
        check_eq({name, ":timeout_err"}, 32'(timeout_err), 32'(e_terr));
        check_eq({name, ":total"}, 32'(total_count), 32'(e_tot));
        check_eq({name, ":correct"}, 32'(correct_count), 32'(e_cor));
        break;
      end
    end
    @(negedge clk);
    check_eq({name, ":post_done"}, 32'(done), 32'(0));
    check_eq({name, ":post_busy"}, 32'(busy), 32'(0));
    check_eq({name, ":hold_total"}, 32'(total_count), 32'(e_tot));
    check_eq({name, ":hold_terr"}, 32'(timeout_err), 32'(e_terr));
    repeat (3) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, ":busy"}, 32'(busy), 32'(0));
    check_eq({tag, ":done"}, 32'(done), 32'(0));
    check_eq({tag, ":terr"}, 32'(timeout_err), 32'(0));
    check_eq({tag, ":core_start"}, 32'(core_start), 32'(0));
    check_eq({tag, ":sample_done"}, 32'(sample_done), 32'(0));
    check_eq({tag, ":sample_match"}, 32'(sample_match), 32'(0));
    check_eq({tag, ":addr"}, 32'(sample_addr), 32'(0));
    check_eq({tag, ":total"}, 32'(total_count), 32'(0));
    check_eq({tag, ":correct"}, 32'(correct_count), 32'(0));
  endtask

  task automatic set_tables(input int l0, input int l1, input int l2, input int l3);
    lat_tab[0] = l0; lat_tab[1] = l1; lat_tab[2] = l2; lat_tab[3] = l3;
  endtask

  initial begin
    int k;
    int cnt;
    labels[0] = 8'd3; labels[1] = 8'd1; labels[2] = 8'd4; labels[3] = 8'd1;
    res_tab[0] = 8'd3; res_tab[1] = 8'd2; res_tab[2] = 8'd4; res_tab[3] = 8'd1;
    set_tables(2, 2, 2, 2);

    // Reset held with start asserted.
    rst = 1'b0; start = 1'b1;
    @(negedge clk); check_zero("reset1");
    @(negedge clk); check_zero("reset2");
    rst = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("idle");

    run_batch("normal");
    set_tables(1, 1, 1, 1);
    run_batch("minlat");
    set_tables(2, 2, 0, 2);
    run_batch("timeout");
    set_tables(2, 3, 1, 2);
    run_batch("after_timeout");

    mid_start = 1'b1; stray_en = 1'b1;
    set_tables(1, 3, 15, 2);
    run_batch("ignored");
    mid_start = 1'b0; stray_en = 1'b0;

    // Reset during WAIT of sample 1.
    set_tables(2, 10, 2, 2);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0;
    while (k < 50 && !(core_start === 1'b1 && sample_addr == AW'(1))) begin
      @(negedge clk); k++;
    end
    check_eq("midrst:reach_s1", 32'(k < 50), 32'(1));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_zero("midrst");
    rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || core_start !== 1'b0) cnt++;
    end
    check_eq("midrst:quiet", 32'(cnt), 32'(0));
    set_tables(2, 2, 2, 2);
    run_batch("after_midrst");

    // Randomized batches.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < int'(NS); i++) begin
        labels[i]  = LW'($urandom_range(0, 3));
        res_tab[i] = LW'($urandom_range(0, 3));
        lat_tab[i] = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
      end
      if (r == 7) lat_tab[NS-1] = int'(TO) - 1;
      run_batch($sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
